// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder/subtractor, one full-adder slice
//             reused LSB-first with a carry flop; sum/cout/ovf + done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                 c_CNT_W  = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_c;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_load;
    logic               w_last;
    logic               w_s;
    logic               w_carry;
    logic [WIDTH-1:0]   w_res_next;

    assign w_load  = start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));
    assign w_last  = (r_state == c_S_SHIFT) && (r_cnt == c_LAST);
    assign w_s     = r_a[0] ^ r_b[0] ^ r_c;
    assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

    // Only WIDTH-1 earlier bits need storage; the final bit comes straight from the slice.
    if (WIDTH == 1) begin : g_res_w1
        assign w_res_next = w_s;
    end else begin : g_res_wn
        logic [WIDTH-2:0] r_res;

        assign w_res_next = {w_s, r_res};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_res <= '0;
            end else if (r_state == c_S_SHIFT) begin
                r_res <= w_res_next[WIDTH-1:1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:  if (start) w_next_state = c_S_SHIFT;
            c_S_SHIFT: if (r_cnt == c_LAST) w_next_state = c_S_DONE;
            c_S_DONE:  w_next_state = start ? c_S_SHIFT : c_S_IDLE;
            default:   w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_S_SHIFT);
        done = (r_state == c_S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (w_load) begin
                // Subtract as a + ~b + 1.
                r_a   <= a;
                r_b   <= op ? ~b : b;
                r_c   <= op ? 1'b1 : cin;
                r_cnt <= '0;
            end else if (r_state == c_S_SHIFT) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_c   <= w_carry;
                r_cnt <= r_cnt + c_ONE;
            end
            // r_c on the final step is the carry into the MSB.
            if (w_last) begin
                sum  <= w_res_next;
                cout <= w_carry;
                ovf  <= r_c ^ w_carry;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, op8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start1, op1, cin1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    int n_cmp = 0;
    int n_err = 0;
    int prev8 = 0;
    int prev1 = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
        .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input bit op, input int a, input int b,
                                  input bit cin, output int s, output bit co, output bit ov);
        int m  = 1 << w;
        int sa = (a >= m / 2) ? a - m : a;
        int sb = (b >= m / 2) ? b - m : b;
        int r;
        if (op) begin
            s  = (a - b + m) % m;
            co = (a >= b);
            r  = sa - sb;
        end else begin
            s  = (a + b + int'(cin)) % m;
            co = ((a + b + int'(cin)) >= m);
            r  = sa + sb + int'(cin);
        end
        ov = (r > m / 2 - 1) || (r < -(m / 2));
    endfunction

    task automatic run8(input bit op, input int a, input int b, input bit cin, input bit from_done);
        int es;
        bit ec, eo;
        if (!from_done) begin
            @(negedge clk);
            check("done8_pulse", done8, 0);
        end
        model(8, op, a, b, cin, es, ec, eo);
        start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin;
        @(negedge clk);
        start8 = 1'b0;
        // Inputs (including start) are scrambled during SHIFT; none may matter.
        for (int i = 0; i < 8; i++) begin
            check("busy8", busy8, 1);
            check("done8_early", done8, 0);
            check("hold8", sum8, prev8);
            start8 = 1'($urandom); op8 = 1'($urandom); cin8 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
        check("done8", done8, 1);
        check("busy8_done", busy8, 0);
        check("sum8", sum8, es);
        check("cout8", cout8, ec);
        check("ovf8", ovf8, eo);
        prev8 = es;
    endtask

    task automatic run1(input bit op, input int a, input int b, input bit cin);
        int es;
        bit ec, eo;
        @(negedge clk);
        check("done1_pulse", done1, 0);
        model(1, op, a, b, cin, es, ec, eo);
        start1 = 1'b1; op1 = op; a1 = a[0:0]; b1 = b[0:0]; cin1 = cin;
        @(negedge clk);
        start1 = 1'b0;
        check("busy1", busy1, 1);
        check("hold1", sum1, prev1);
        a1 = ~a1; b1 = ~b1; cin1 = ~cin1; op1 = ~op1;
        @(negedge clk);
        check("done1", done1, 1);
        check("busy1_done", busy1, 0);
        check("sum1", sum1, es);
        check("cout1", cout1, ec);
        check("ovf1", ovf1, eo);
        prev1 = es;
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 0; op8 = 0; cin8 = 0; a8 = '0; b8 = '0;
        start1 = 0; op1 = 0; cin1 = 0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", cout8, 0);
        check("rst_ovf8", ovf8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_busy1", busy1, 0);
        rst_n = 1'b1;

        run8(0, 8'h00, 8'h00, 0, 0);
        run8(0, 8'hFF, 8'h01, 0, 0);
        run8(0, 8'h7F, 8'h01, 0, 0);
        run8(0, 8'h80, 8'h80, 1, 0);
        run8(1, 8'h05, 8'h07, 0, 0);
        run8(1, 8'h05, 8'h07, 1, 0);
        run8(1, 8'h80, 8'h01, 0, 0);
        run8(1, 8'h80, 8'h01, 1, 0);
        run8(0, 8'h11, 8'h22, 0, 0);
        run8(0, 8'h01, 8'h01, 0, 0);
        run8(0, 8'h01, 8'h01, 0, 1);
        run8(1, 8'h40, 8'hC0, 0, 1);

        // Reset asserted mid-operation must clear everything and yield no done.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h33; op8 = 0; cin8 = 1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_sum8", sum8, 0);
        check("midrst_cout8", cout8, 0);
        check("midrst_ovf8", ovf8, 0);
        check("midrst_busy8", busy8, 0);
        check("midrst_done8", done8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev8 = 0;
        prev1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("postrst_done8", done8, 0);
            check("postrst_busy8", busy8, 0);
        end
        run8(0, 8'h5A, 8'h33, 1, 0);

        for (int i = 0; i < 60; i++) begin
            run8(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 1'($urandom), 1'($urandom));
        end

        for (int op = 0; op < 2; op++)
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < 2; b++)
                    for (int c = 0; c < 2; c++)
                        run1(op[0], a, b, c[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
